// File: rtl/cfm_reset_sequencer_pkg.sv
// Shared definitions for the CFM reset sequencer: state encoding and width helper.
package cfm_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    DELAY     = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3
  } seq_state_e;

  // Bits needed to hold values 0 .. num_values-1 (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned num_values);
    return (num_values <= 1) ? 1 : $clog2(num_values);
  endfunction

endpackage

// File: rtl/cfm_lock_filter.sv
// PLL lock synchroniser and consecutive-cycle stability filter.
module cfm_lock_filter
  import cfm_reset_sequencer_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = 4
) (
  input  logic clk_core,
  input  logic reset,
  input  logic pll_locked,
  input  logic enable,
  output logic lock_sync,
  output logic lock_stable
);

  localparam int unsigned LOCK_W = cnt_width(LOCK_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);

  logic              sync1_q;
  logic              sync2_q;
  logic [LOCK_W-1:0] lock_cnt_q;

  // Two-stage synchroniser, then count consecutive locked cycles while enabled.
  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
      if (!enable || !sync2_q)
        lock_cnt_q <= '0;
      else if (lock_cnt_q != LOCK_MAX)
        lock_cnt_q <= lock_cnt_q + 1'b1;
    end
  end

  assign lock_sync   = sync2_q;
  assign lock_stable = (lock_cnt_q == LOCK_MAX);

endmodule

// File: rtl/cfm_reset_sequencer.sv
// Board-level reset sequencer: lock filtering, hold delay, staggered releases.
module cfm_reset_sequencer
  import cfm_reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS  = 2,
  parameter int unsigned LOCK_CYCLES  = 4,
  parameter int unsigned DELAY_CYCLES = 128,
  parameter int unsigned STAGE_CYCLES = 16
) (
  input  logic                   clk_core,
  input  logic                   reset,
  input  logic                   pll_locked,
  input  logic                   sw_reset_req,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   ready,
  output logic                   lock_lost,
  output logic [2:0]             state_o
);

  localparam int unsigned DLY_W = cnt_width(DELAY_CYCLES);
  localparam int unsigned STG_W = cnt_width(STAGE_CYCLES);
  localparam int unsigned IDX_W = cnt_width(NUM_DOMAINS);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY_CYCLES - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

  seq_state_e             state_q, state_d;
  logic [DLY_W-1:0]       dly_q, dly_d;
  logic [STG_W-1:0]       stg_q, stg_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic                   ready_q, ready_d;
  logic                   lost_q, lost_d;
  logic                   lock_sync;
  logic                   lock_stable;

  cfm_lock_filter #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lock_filter (
    .clk_core   (clk_core),
    .reset      (reset),
    .pll_locked (pll_locked),
    .enable     (state_q == WAIT_LOCK),
    .lock_sync  (lock_sync),
    .lock_stable(lock_stable)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      dly_q   <= '0;
      stg_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      stg_q   <= stg_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
    end
  end

  // Next-state and next-output logic; lock loss overrides the software request.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    stg_d   = stg_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    ready_d = ready_q;
    lost_d  = lost_q;

    case (state_q)
      WAIT_LOCK: begin
        rst_n_d = '0;
        ready_d = 1'b0;
        dly_d   = '0;
        stg_d   = '0;
        idx_d   = '0;
        if (lock_stable)
          state_d = DELAY;
      end
      DELAY: begin
        if (dly_q == DLY_LAST) begin
          dly_d      = '0;
          stg_d      = '0;
          rst_n_d[0] = 1'b1;
          if (NUM_DOMAINS == 1) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            state_d = RELEASE;
            idx_d   = IDX_W'(1);
          end
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      RELEASE: begin
        if (stg_q == STG_LAST) begin
          stg_d          = '0;
          rst_n_d[idx_q] = 1'b1;
          idx_d          = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end else begin
          stg_d = stg_q + 1'b1;
        end
      end
      RUN: ;
      default: state_d = WAIT_LOCK;
    endcase

    // Once past WAIT_LOCK, a lock drop or software request restarts the sequence.
    if (state_q != WAIT_LOCK) begin
      if (!lock_sync) begin
        state_d = WAIT_LOCK;
        rst_n_d = '0;
        ready_d = 1'b0;
        dly_d   = '0;
        stg_d   = '0;
        idx_d   = '0;
        if (state_q == RUN)
          lost_d = 1'b1;
      end else if (sw_reset_req) begin
        state_d = DELAY;
        rst_n_d = '0;
        ready_d = 1'b0;
        dly_d   = '0;
        stg_d   = '0;
        idx_d   = '0;
      end
    end
  end

  assign rst_n_out = rst_n_q;
  assign ready     = ready_q;
  assign lock_lost = lost_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_cfm_reset_sequencer.sv
// Directed bench for cfm_reset_sequencer: default instance plus a 4-domain, 1-cycle-stage instance.
module tb_cfm_reset_sequencer;

  logic       clk_core = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic [1:0] rst_n_out;
  logic       ready;
  logic       lock_lost;
  logic [2:0] state_o;
  logic [3:0] rst_n_out4;
  logic       ready4;
  logic       lock_lost4;
  logic [2:0] state_o4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;

  typedef struct {
    int         k;
    logic [1:0] rst;
    logic       rdy;
    logic [2:0] st;
    logic [3:0] rst4;
    logic       rdy4;
    logic [2:0] st4;
  } vec_t;

  vec_t tbl[10];

  cfm_reset_sequencer dut (
    .clk_core    (clk_core),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .sw_reset_req(sw_reset_req),
    .rst_n_out   (rst_n_out),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .state_o     (state_o)
  );

  cfm_reset_sequencer #(
    .NUM_DOMAINS (4),
    .STAGE_CYCLES(1)
  ) dut4 (
    .clk_core    (clk_core),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .sw_reset_req(sw_reset_req),
    .rst_n_out   (rst_n_out4),
    .ready       (ready4),
    .lock_lost   (lock_lost4),
    .state_o     (state_o4)
  );

  always #5 clk_core = ~clk_core;

  task automatic tick();
    @(posedge clk_core);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int k);
    while (cyc < base + k) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc - base);
    end
  endtask

  task automatic chk_main(input string nm, input logic [1:0] r, input logic rd,
                          input logic [2:0] st, input logic ll);
    chk({nm, " rst_n_out"}, 32'(rst_n_out), 32'(r));
    chk({nm, " ready"}, 32'(ready), 32'(rd));
    chk({nm, " state_o"}, 32'(state_o), 32'(st));
    chk({nm, " lock_lost"}, 32'(lock_lost), 32'(ll));
  endtask

  // Hold reset for three cycles, then present a steady lock; the next edge is E (k=0).
  task automatic do_reset();
    reset = 1'b1;
    pll_locked = 1'b0;
    sw_reset_req = 1'b0;
    repeat (3) tick();
    chk_main("in_reset", 2'b00, 1'b0, 3'd0, 1'b0);
    chk("in_reset rst4", 32'(rst_n_out4), 32'h0);
    reset = 1'b0;
    pll_locked = 1'b1;
    base = cyc + 1;
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < 10; i++) begin
      wait_to(tbl[i].k);
      chk_main($sformatf("%s[%0d]", nm, tbl[i].k), tbl[i].rst, tbl[i].rdy, tbl[i].st, 1'b0);
      chk($sformatf("%s[%0d] rst4", nm, tbl[i].k), 32'(rst_n_out4), 32'(tbl[i].rst4));
      chk($sformatf("%s[%0d] ready4", nm, tbl[i].k), 32'(ready4), 32'(tbl[i].rdy4));
      chk($sformatf("%s[%0d] state4", nm, tbl[i].k), 32'(state_o4), 32'(tbl[i].st4));
    end
  endtask

  initial begin
    tbl[0] = '{0,   2'b00, 1'b0, 3'd0, 4'b0000, 1'b0, 3'd0};
    tbl[1] = '{5,   2'b00, 1'b0, 3'd0, 4'b0000, 1'b0, 3'd0};
    tbl[2] = '{6,   2'b00, 1'b0, 3'd1, 4'b0000, 1'b0, 3'd1};
    tbl[3] = '{133, 2'b00, 1'b0, 3'd1, 4'b0000, 1'b0, 3'd1};
    tbl[4] = '{134, 2'b01, 1'b0, 3'd2, 4'b0001, 1'b0, 3'd2};
    tbl[5] = '{135, 2'b01, 1'b0, 3'd2, 4'b0011, 1'b0, 3'd2};
    tbl[6] = '{136, 2'b01, 1'b0, 3'd2, 4'b0111, 1'b0, 3'd2};
    tbl[7] = '{137, 2'b01, 1'b0, 3'd2, 4'b1111, 1'b1, 3'd3};
    tbl[8] = '{149, 2'b01, 1'b0, 3'd2, 4'b1111, 1'b1, 3'd3};
    tbl[9] = '{150, 2'b11, 1'b1, 3'd3, 4'b1111, 1'b1, 3'd3};

    // Default sequence on both instances.
    tick();
    do_reset();
    run_table("seq");

    // One-cycle lock glitch sampled at E+2: filter restarts, release shifts by 3.
    do_reset();
    wait_to(1);
    pll_locked = 1'b0;
    wait_to(2);
    pll_locked = 1'b1;
    wait_to(8);
    chk_main("glitch8", 2'b00, 1'b0, 3'd0, 1'b0);
    wait_to(9);
    chk_main("glitch9", 2'b00, 1'b0, 3'd1, 1'b0);
    wait_to(136);
    chk_main("glitch136", 2'b00, 1'b0, 3'd1, 1'b0);
    wait_to(137);
    chk_main("glitch137", 2'b01, 1'b0, 3'd2, 1'b0);
    wait_to(152);
    chk_main("glitch152", 2'b01, 1'b0, 3'd2, 1'b0);
    wait_to(153);
    chk_main("glitch153", 2'b11, 1'b1, 3'd3, 1'b0);
    wait_to(160);

    // Software reset for 5 cycles from RUN: back to DELAY, no relock needed.
    sw_reset_req = 1'b1;
    base = cyc + 1;
    wait_to(0);
    chk_main("swr0", 2'b00, 1'b0, 3'd1, 1'b0);
    wait_to(4);
    chk_main("swr4", 2'b00, 1'b0, 3'd1, 1'b0);
    sw_reset_req = 1'b0;
    wait_to(131);
    chk_main("swr131", 2'b00, 1'b0, 3'd1, 1'b0);
    wait_to(132);
    chk_main("swr132", 2'b01, 1'b0, 3'd2, 1'b0);
    wait_to(147);
    chk_main("swr147", 2'b01, 1'b0, 3'd2, 1'b0);
    wait_to(148);
    chk_main("swr148", 2'b11, 1'b1, 3'd3, 1'b0);
    wait_to(155);

    // Lock drop for one cycle in RUN: resets fall after the synchroniser, lock_lost sticks.
    pll_locked = 1'b0;
    base = cyc + 1;
    wait_to(0);
    pll_locked = 1'b1;
    wait_to(1);
    chk_main("loss1", 2'b11, 1'b1, 3'd3, 1'b0);
    wait_to(2);
    chk_main("loss2", 2'b00, 1'b0, 3'd0, 1'b1);
    wait_to(7);
    chk_main("loss7", 2'b00, 1'b0, 3'd1, 1'b1);
    wait_to(134);
    chk_main("loss134", 2'b00, 1'b0, 3'd1, 1'b1);
    wait_to(135);
    chk_main("loss135", 2'b01, 1'b0, 3'd2, 1'b1);
    wait_to(150);
    chk_main("loss150", 2'b01, 1'b0, 3'd2, 1'b1);
    wait_to(151);
    chk_main("loss151", 2'b11, 1'b1, 3'd3, 1'b1);

    // Asynchronous reset mid-RELEASE, then a full rerun.
    do_reset();
    wait_to(140);
    chk_main("pre_areset", 2'b01, 1'b0, 3'd2, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_main("areset", 2'b00, 1'b0, 3'd0, 1'b0);
    chk("areset rst4", 32'(rst_n_out4), 32'h0);
    tick();
    do_reset();
    run_table("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
